fifo_ctrl: RTL and testbench
============================

# fifo_ctrl

Pointer, occupancy and flag controller that sequences the 8-entry dual-port `memory` block as a synchronous FIFO. It owns the write and read addresses and enables, accepts push/pop requests from the PCIE lane logic, and produces full/empty, programmable almost-full/almost-empty, occupancy count, read-data-valid and sticky error flags. It sits between the requesting logic and `memory`. `memory` carries the data path (`Fifo_Data_in` / `Fifo_Data_out`); this block carries no data.

## Interface
- `ADDR_WIDTH`, default 3: address width; depth is `DEPTH = 2**ADDR_WIDTH`, which is 8.
- `AF_DEFAULT`, default 6: almost-full threshold loaded at reset.
- `AE_DEFAULT`, default 2: almost-empty threshold loaded at reset.

Ports:
- `clk`  in  1  single clock. All state updates on its rising edge.
- `reset_L`  in  1  asynchronous, active-low reset.
- `push`  in  1  write request. `Fifo_Data_in` must be valid at `memory` in the same cycle.
- `pop`  in  1  read request.
- `thr_almost_full`  in  ADDR_WIDTH+1  almost-full threshold, latched in INIT.
- `thr_almost_empty`  in  ADDR_WIDTH+1  almost-empty threshold, latched in INIT.
- `err_clear`  in  1  synchronous clear of the sticky error flags.
- `write_enable`  out  1  to `memory`.
- `write_addr`  out  ADDR_WIDTH  to `memory`; equals the write pointer.
- `read_enable`  out  1  to `memory`.
- `read_addr`  out  ADDR_WIDTH  to `memory`; equals the read pointer.
- `pop_valid`  out  1  registered. High in the cycle `Fifo_Data_out` holds a popped word.
- `count`  out  ADDR_WIDTH+1  occupancy, range 0..DEPTH.
- `full`, `empty`, `almost_full`, `almost_empty`  out  1 each  status flags.
- `overflow_err`, `underflow_err`  out  1 each  sticky error flags.
- `ctrl_ready`  out  1  high while in ACTIVE.

## Operation
- **FSM:** INIT and ACTIVE.
  - Reset forces INIT.
  - INIT lasts exactly one clock after `reset_L` deasserts. It latches both threshold inputs, then moves to ACTIVE.
  - ACTIVE is held until the next reset.
  - `push` and `pop` are ignored in INIT. In INIT both enables are 0 and no error is flagged.
- **Accept rules (ACTIVE only):**
  - `pop_ok = pop & !empty`.
  - `push_ok = push & (!full | pop_ok)`. A push while full is accepted only if a pop is accepted in the same cycle. This is safe because `memory` returns the old word on a same-address read/write.
  - A pop while empty is always rejected, even with a simultaneous push.
- **Memory enables:** `write_enable = push_ok` and `read_enable = pop_ok`. Both are combinational from registered state and the requests.
- **Pointers:** each pointer increments by 1 per accepted operation and wraps from DEPTH-1 to 0 by natural overflow.
- **Count:**
  - +1 on push only.
  - -1 on pop only.
  - Unchanged when both or neither are accepted.
- **Flags:** combinational decodes of the registered `count` and latched thresholds.
  - `full = (count == DEPTH)`.
  - `empty = (count == 0)`.
  - `almost_full = (count >= thr_af)`.
  - `almost_empty = (count <= thr_ae)`.
- **Errors:**
  - `overflow_err` sets on the edge where `push & !push_ok` in ACTIVE.
  - `underflow_err` sets on the edge where `pop & !pop_ok` in ACTIVE.
  - Both hold until `err_clear` or reset.
  - If `err_clear` and a new error occur in the same cycle, set wins.
  - A rejected request changes no pointer and no count.
- **Reset (asynchronous, any time including mid-operation):**
  - Pointers 0, `count` 0, `pop_valid` 0, errors 0.
  - Thresholds reload to AF_DEFAULT/AE_DEFAULT; state goes to INIT.
  - Resulting outputs: `empty` 1, `full` 0, `almost_empty` 1, `almost_full` 0, `ctrl_ready` 0, both enables 0.
  - Memory contents are not cleared and are never exposed, because `pop_valid` stays 0.

## Timing
- **Push:** accepted at edge N. The word is written into `memory` at edge N; `count`, the write pointer and flags update after edge N.
- **Pop:** accepted at edge N. `memory` registers the data at edge N, and `pop_valid` is set at edge N. `Fifo_Data_out` and `pop_valid` are therefore valid together in cycle N+1, a read latency of 1 cycle.
- **Back-to-back:** one push and one pop per cycle are sustained with no bubbles.
- **Reset release:** `reset_L` rises before edge R. Edge R ends INIT; `ctrl_ready` is 1 after edge R; the first accepted request is at edge R+1.
- **Latched-threshold checks:**
  - A threshold of 0 makes `almost_full` permanently 1.
  - A threshold of DEPTH makes `almost_empty` permanently 1. Both are legal.

## Test plan
- **Reset/INIT:** hold `reset_L`=0 with random push/pop → all outputs at reset values. Release with thresholds 6/2 → `ctrl_ready`=1 one edge later; a push issued during INIT is ignored and `count` stays 0.
- **Fill:** 8 pushes of 0x001..0x008 → `almost_full` rises when `count` reaches 6; `full`=1 at `count` 8. A 9th push gives `write_enable`=0, `overflow_err`=1, `count`=8. `err_clear` then clears `overflow_err`.
- **Drain:** 8 pops → `pop_valid` with data 0x001..0x008 in order, one cycle after each pop. `almost_empty` rises at `count` 2 and `empty` at 0. A 9th pop gives `underflow_err`=1 with no `pop_valid`.
- **Wrap-around:** 20 words pushed and popped in bursts of 5 → addresses wrap 7→0 and all 20 words come out in order. `count` never exceeds 5.
- **Simultaneous push+pop at boundaries:**
  - At full: `count` stays 8, the oldest word is popped, no overflow.
  - At empty: the push is accepted, the pop is rejected, `underflow_err`=1, `count`=1.
- **Reset mid-operation:** with `count`=5, drive `reset_L` low between edges → `count`=0, `empty`=1 and `pop_valid`=0 immediately, without waiting for a clock edge. After release and INIT, a push then pop returns the new word, not stale data.

Source files
------------

// File: rtl/fifo_ctrl_if.sv
// Bundle of the request, threshold, memory-control and status signals that
// connect the requesting lane logic to the FIFO controller.
interface fifo_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 3
);
    // Requests and configuration from the lane logic
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH:0]   thr_almost_full;
    logic [ADDR_WIDTH:0]   thr_almost_empty;
    logic                  err_clear;

    // Memory control towards the dual-port memory
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic                  read_enable;
    logic [ADDR_WIDTH-1:0] read_addr;

    // Status back to the lane logic
    logic                  pop_valid;
    logic [ADDR_WIDTH:0]   count;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow_err;
    logic                  underflow_err;
    logic                  ctrl_ready;

    // Requesting side: issues push/pop and observes status
    modport master (
        output push, pop, thr_almost_full, thr_almost_empty, err_clear,
        input  write_enable, write_addr, read_enable, read_addr,
        input  pop_valid, count, full, empty, almost_full, almost_empty,
        input  overflow_err, underflow_err, ctrl_ready
    );

    // Controller side
    modport slave (
        input  push, pop, thr_almost_full, thr_almost_empty, err_clear,
        output write_enable, write_addr, read_enable, read_addr,
        output pop_valid, count, full, empty, almost_full, almost_empty,
        output overflow_err, underflow_err, ctrl_ready
    );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and flag controller sequencing a 2**ADDR_WIDTH-entry
// dual-port memory as a synchronous FIFO. Carries no data itself; it owns
// the memory addresses/enables and reports occupancy, thresholds and errors.
module fifo_ctrl #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned AF_DEFAULT = 6,
    parameter int unsigned AE_DEFAULT = 2
) (
    input  logic         clk,
    input  logic         reset_L,
    fifo_ctrl_if.slave   bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    localparam logic [CW-1:0]         COUNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0]         COUNT_ONE  = CW'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);
    localparam logic [CW-1:0]         AF_RESET   = CW'(AF_DEFAULT);
    localparam logic [CW-1:0]         AE_RESET   = CW'(AE_DEFAULT);

    typedef enum logic {
        S_INIT,
        S_ACTIVE
    } state_t;

    state_t                state;
    logic                  ready_q;
    logic [CW-1:0]         thr_af;
    logic [CW-1:0]         thr_ae;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  pop_valid_q;
    logic                  overflow_q;
    logic                  underflow_q;

    logic                  active;
    logic                  is_full;
    logic                  is_empty;
    logic                  pop_ok;
    logic                  push_ok;
    logic                  push_reject;
    logic                  pop_reject;

    // Accept decisions from registered occupancy and the current requests
    always_comb begin
        active      = (state == S_ACTIVE);
        is_full     = (count_q == COUNT_FULL);
        is_empty    = (count_q == '0);
        pop_ok      = active & bus.pop & ~is_empty;
        // a push into a full FIFO is safe when a pop frees the slot in the
        // same cycle: the memory returns the old word on a same-address R/W
        push_ok     = active & bus.push & (~is_full | pop_ok);
        push_reject = active & bus.push & ~push_ok;
        pop_reject  = active & bus.pop  & ~pop_ok;
    end

    // Two-state sequencer: one INIT clock latches thresholds, then ACTIVE
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state   <= S_INIT;
            ready_q <= 1'b0;
            thr_af  <= AF_RESET;
            thr_ae  <= AE_RESET;
        end else begin
            case (state)
                S_INIT: begin
                    thr_af  <= bus.thr_almost_full;
                    thr_ae  <= bus.thr_almost_empty;
                    state   <= S_ACTIVE;
                    ready_q <= 1'b1;
                end
                S_ACTIVE: begin
                    state   <= S_ACTIVE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= S_INIT;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Write/read pointers advance once per accepted operation, wrapping naturally
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Occupancy: net change of accepted push minus accepted pop
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            count_q <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + COUNT_ONE;
                2'b01:   count_q <= count_q - COUNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Read data is valid the cycle after an accepted pop (memory read latency)
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            pop_valid_q <= 1'b0;
        end else begin
            pop_valid_q <= pop_ok;
        end
    end

    // Sticky errors: a new rejection takes priority over a same-cycle clear
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push_reject) begin
                overflow_q <= 1'b1;
            end else if (bus.err_clear) begin
                overflow_q <= 1'b0;
            end
            if (pop_reject) begin
                underflow_q <= 1'b1;
            end else if (bus.err_clear) begin
                underflow_q <= 1'b0;
            end
        end
    end

    // Memory control and status decodes
    always_comb begin
        bus.write_enable  = push_ok;
        bus.write_addr    = wr_ptr;
        bus.read_enable   = pop_ok;
        bus.read_addr     = rd_ptr;
        bus.pop_valid     = pop_valid_q;
        bus.count         = count_q;
        bus.full          = is_full;
        bus.empty         = is_empty;
        bus.almost_full   = (count_q >= thr_af);
        bus.almost_empty  = (count_q <= thr_ae);
        bus.overflow_err  = overflow_q;
        bus.underflow_err = underflow_q;
        bus.ctrl_ready    = ready_q;
    end
endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: a queue-based FIFO model predicts every
// output each cycle, a small memory stand-in carries data so word order can
// be checked, and directed phases pin the model with literal expectations.
module tb_fifo_ctrl;
    localparam int unsigned AW    = 3;
    localparam int          DEPTH = 8;

    logic clk;
    logic reset_L;
    logic [11:0] din;
    logic [11:0] dout;
    logic [11:0] mem [DEPTH];

    int total = 0;
    int bad   = 0;
    bit run_cmp = 0;

    fifo_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    fifo_ctrl #(
        .ADDR_WIDTH(AW),
        .AF_DEFAULT(6),
        .AE_DEFAULT(2)
    ) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory stand-in: write at the edge, registered read returning the old word
    always @(posedge clk) begin
        if (bus.write_enable === 1'b1) mem[bus.write_addr] <= din;
        if (bus.read_enable === 1'b1) dout <= mem[bus.read_addr];
    end

    // ---------------- behavioural model ----------------
    int q[$];
    int m_phase;          // 0 = waiting for first clock after reset, 1 = running
    int m_thr_af, m_thr_ae;
    bit m_ovf, m_udf, m_pv;
    int m_pd;
    int m_wr, m_rd;

    always @(posedge clk or negedge reset_L) begin
        bit pok, wok;
        if (!reset_L) begin
            q.delete();
            m_phase  = 0;
            m_thr_af = 6;
            m_thr_ae = 2;
            m_ovf    = 0;
            m_udf    = 0;
            m_pv     = 0;
            m_wr     = 0;
            m_rd     = 0;
        end else if (m_phase == 0) begin
            m_thr_af = int'(bus.thr_almost_full);
            m_thr_ae = int'(bus.thr_almost_empty);
            m_phase  = 1;
            m_pv     = 0;
        end else begin
            pok = bus.pop && (q.size() > 0);
            wok = bus.push && (q.size() < DEPTH || pok);
            if (bus.push && !wok) m_ovf = 1;
            else if (bus.err_clear) m_ovf = 0;
            if (bus.pop && !pok) m_udf = 1;
            else if (bus.err_clear) m_udf = 0;
            m_pv = pok;
            if (pok) begin
                m_pd = q.pop_front();
                m_rd = (m_rd + 1) % DEPTH;
            end
            if (wok) begin
                q.push_back(int'(din));
                m_wr = (m_wr + 1) % DEPTH;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare();
        int  n;
        bit  pok, wok;
        n   = q.size();
        pok = (m_phase == 1) && bus.pop && (n > 0);
        wok = (m_phase == 1) && bus.push && (n < DEPTH || pok);
        chk("write_enable",  bus.write_enable,  wok);
        chk("read_enable",   bus.read_enable,   pok);
        chk("write_addr",    bus.write_addr,    m_wr);
        chk("read_addr",     bus.read_addr,     m_rd);
        chk("count",         bus.count,         n);
        chk("full",          bus.full,          n == DEPTH);
        chk("empty",         bus.empty,         n == 0);
        chk("almost_full",   bus.almost_full,   n >= m_thr_af);
        chk("almost_empty",  bus.almost_empty,  n <= m_thr_ae);
        chk("overflow_err",  bus.overflow_err,  m_ovf);
        chk("underflow_err", bus.underflow_err, m_udf);
        chk("ctrl_ready",    bus.ctrl_ready,    m_phase == 1);
        chk("pop_valid",     bus.pop_valid,     m_pv);
        if (m_pv) chk("pop_data", dout, m_pd);
    endtask

    // single compare process, mid low phase of the clock
    always @(negedge clk) begin
        #2;
        if (run_cmp) compare();
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit p, input bit r, input bit c, input logic [11:0] d);
        @(negedge clk);
        bus.push      = p;
        bus.pop       = r;
        bus.err_clear = c;
        din           = d;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] af, input logic [3:0] ae);
        @(negedge clk);
        reset_L = 1'b0;
        bus.thr_almost_full  = af;
        bus.thr_almost_empty = ae;
        repeat (2) cyc(1'($urandom), 1'($urandom), 1'b0, 12'h0);
        @(negedge clk);
        reset_L   = 1'b1;
        bus.push  = 1'b0;
        bus.pop   = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_L              = 1'b1;
        bus.push             = 1'b0;
        bus.pop              = 1'b0;
        bus.err_clear        = 1'b0;
        bus.thr_almost_full  = 4'd6;
        bus.thr_almost_empty = 4'd2;
        din                  = '0;
        #1 reset_L = 1'b0;
        run_cmp = 1;

        // reset held with random requests
        repeat (4) cyc(1'($urandom), 1'($urandom), 1'b0, 12'h0);
        #2;
        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_ae",    bus.almost_empty, 1);
        chk("rst_ready", bus.ctrl_ready, 0);

        // release with a push during INIT: ignored
        @(negedge clk);
        reset_L  = 1'b1;
        bus.push = 1'b1;
        bus.pop  = 1'b0;
        din      = 12'h0FF;
        settle();
        chk("init_ready", bus.ctrl_ready, 1);
        chk("init_count", bus.count, 0);

        // fill 1..8, then a rejected 9th push
        for (int i = 1; i <= 8; i++) begin
            cyc(1, 0, 0, 12'(i));
            settle();
            chk("fill_af", bus.almost_full, i >= 6);
        end
        chk("fill_full", bus.full, 1);
        cyc(1, 0, 0, 12'h009);
        settle();
        chk("ovf_set",   bus.overflow_err, 1);
        chk("ovf_count", bus.count, 8);
        cyc(0, 0, 1, 12'h0);
        settle();
        chk("ovf_clear", bus.overflow_err, 0);

        // drain in order, then a rejected 9th pop
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 1, 0, 12'h0);
            settle();
            chk("drain_valid", bus.pop_valid, 1);
            chk("drain_data",  dout, i);
            chk("drain_ae",    bus.almost_empty, (8 - i) <= 2);
        end
        chk("drain_empty", bus.empty, 1);
        cyc(0, 1, 0, 12'h0);
        settle();
        chk("udf_set",   bus.underflow_err, 1);
        chk("udf_valid", bus.pop_valid, 0);
        cyc(0, 0, 1, 12'h0);

        // wrap-around: 20 words in bursts of 5
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 5; i++) cyc(1, 0, 0, 12'(12'h200 + b * 5 + i));
            for (int i = 0; i < 5; i++) cyc(0, 1, 0, 12'h0);
        end
        settle();
        chk("wrap_waddr", bus.write_addr, 4);
        chk("wrap_raddr", bus.read_addr, 4);

        // simultaneous push+pop at full and at empty
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 12'(12'h300 + i));
        cyc(1, 1, 0, 12'h3AA);
        settle();
        chk("full_pp_count", bus.count, 8);
        chk("full_pp_ovf",   bus.overflow_err, 0);
        chk("full_pp_data",  dout, 12'h300);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 12'h0);
        cyc(1, 1, 0, 12'h3BB);
        settle();
        chk("empty_pp_count", bus.count, 1);
        chk("empty_pp_udf",   bus.underflow_err, 1);

        // reset mid-operation with count 5
        cyc(0, 0, 1, 12'h0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 12'(12'h400 + i));
        cyc(0, 0, 0, 12'h0);
        settle();
        chk("mid_pre_count", bus.count, 5);
        cyc(0, 1, 0, 12'h0);
        #3 reset_L = 1'b0;
        #1;
        chk("mid_count", bus.count, 0);
        chk("mid_empty", bus.empty, 1);
        chk("mid_pv",    bus.pop_valid, 0);
        bus.pop = 1'b0;
        cyc(0, 0, 0, 12'h0);
        @(negedge clk);
        reset_L = 1'b1;
        cyc(1, 0, 0, 12'h5A5);
        cyc(0, 1, 0, 12'h0);
        settle();
        chk("mid_new_valid", bus.pop_valid, 1);
        chk("mid_new_data",  dout, 12'h5A5);

        // randomized traffic with boundary and random thresholds
        for (int cfg = 0; cfg < 3; cfg++) begin
            logic [3:0] af, ae;
            af = (cfg == 0) ? 4'd0 : 4'($urandom_range(0, 8));
            ae = (cfg == 0) ? 4'd8 : 4'($urandom_range(0, 8));
            do_reset(af, ae);
            for (int i = 0; i < 200; i++) begin
                cyc($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                    $urandom_range(0, 99) < 10, 12'($urandom));
            end
        end
        cyc(0, 0, 0, 12'h0);
        settle();

        run_cmp = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
